// File: rtl/pid_pkg.sv
// Shared types and defaults for the PID-to-PWM output stage.
// Register widths of duty_t follow the package CNT_WIDTH.
package pid_pkg;
    localparam int D_WIDTH   = 16;
    localparam int Q_BITS    = 13;
    localparam int CNT_WIDTH = 8;
    localparam int Q_ONE     = 1 << Q_BITS;

    typedef logic [CNT_WIDTH:0] duty_t;

    typedef struct packed {
        duty_t duty;
        logic  dir;
        logic  sat;
    } pwm_cmd_t;
endpackage

// File: rtl/pid_pwm_conv.sv
// Combinational conversion of a signed Q-format PID effort into a
// sign-magnitude PWM command (abs, clamp at 1.0, scale to counter range).
module pid_pwm_conv
    import pid_pkg::*;
#(
    parameter int D_WIDTH   = pid_pkg::D_WIDTH,
    parameter int Q_BITS    = pid_pkg::Q_BITS,
    parameter int CNT_WIDTH = pid_pkg::CNT_WIDTH
) (
    input  logic [D_WIDTH-1:0] pid_out,
    output pwm_cmd_t           cmd
);
    localparam int               SHIFT   = Q_BITS - CNT_WIDTH;
    localparam logic [D_WIDTH:0] LSB_ONE = 1;
    localparam logic [D_WIDTH:0] MAG_ONE = LSB_ONE << Q_BITS;

    logic [D_WIDTH:0] ext;
    logic [D_WIDTH:0] mag;
    logic [D_WIDTH:0] mag_c;

    assign ext = {pid_out[D_WIDTH-1], pid_out};

    // One extra bit keeps the magnitude of the most negative input exact.
    always_comb begin
        cmd   = '0;
        mag   = pid_out[D_WIDTH-1] ? (~ext + LSB_ONE) : ext;
        mag_c = mag;
        if (mag > MAG_ONE) begin
            mag_c   = MAG_ONE;
            cmd.sat = 1'b1;
        end
        cmd.duty = duty_t'(mag_c >> SHIFT);
        cmd.dir  = pid_out[D_WIDTH-1];
    end
endmodule

// File: rtl/pid_pwm.sv
// PWM output stage: double-buffered duty command applied on period
// boundaries, sign-magnitude pwm/dir outputs and a period strobe.
module pid_pwm
    import pid_pkg::*;
#(
    parameter int D_WIDTH   = pid_pkg::D_WIDTH,
    parameter int Q_BITS    = pid_pkg::Q_BITS,
    parameter int CNT_WIDTH = pid_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [D_WIDTH-1:0]   pid_out,
    input  logic                 pid_valid,
    output logic                 pwm,
    output logic                 dir,
    output logic                 sat,
    output logic                 period_start,
    output logic [CNT_WIDTH:0]   duty_active
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 enable_q;
    logic                 load_active;
    pwm_cmd_t             conv_cmd;
    pwm_cmd_t             shadow;
    pwm_cmd_t             active;
    pwm_cmd_t             active_next;

    pid_pwm_conv #(
        .D_WIDTH   (D_WIDTH),
        .Q_BITS    (Q_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_conv (
        .pid_out (pid_out),
        .cmd     (conv_cmd)
    );

    // The first enabled cycle only arms the stage: the counter stays at 0 and
    // the active command is loaded, so the first real period starts cleanly.
    always_comb begin
        cnt_next    = '0;
        if (enable && enable_q)
            cnt_next = cnt + CNT_ONE;
        load_active = enable && (!enable_q || cnt == CNT_LAST);
        active_next = pid_valid ? conv_cmd : shadow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            enable_q     <= 1'b0;
            shadow       <= '0;
            active       <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            enable_q     <= enable;
            cnt          <= cnt_next;
            if (pid_valid)
                shadow <= conv_cmd;
            if (load_active)
                active <= active_next;
            pwm          <= enable && enable_q && ({1'b0, cnt} < active.duty);
            period_start <= enable && (cnt_next == '0);
        end
    end

    assign dir         = active.dir;
    assign sat         = active.sat;
    assign duty_active = active.duty;
endmodule

// File: tb/tb_pid_pwm.sv
// Scoreboard bench for pid_pwm: expected per-period commands are queued as
// stimulus is driven and checked at each period_start along with pwm on-time.
module tb_pid_pwm;
    typedef struct {
        int duty;
        int dir;
        int sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pid_out;
    logic        pid_valid;
    logic        pwm;
    logic        dir;
    logic        sat;
    logic        period_start;
    logic [8:0]  duty_active;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t exp_shadow;
    int   monitor_on = 0;
    int   have_prev = 0;
    int   prev_duty = 0;
    int   pwm_count = 0;
    int   lat;

    pid_pwm dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pid_out      (pid_out),
        .pid_valid    (pid_valid),
        .pwm          (pwm),
        .dir          (dir),
        .sat          (sat),
        .period_start (period_start),
        .duty_active  (duty_active)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic exp_t convert(input logic [15:0] v);
        exp_t e;
        int   s;
        int   m;
        s = $signed(v);
        m = (s < 0) ? -s : s;
        e.sat = (m > 8192) ? 1 : 0;
        if (m > 8192)
            m = 8192;
        e.duty = m / 32;
        e.dir  = (s < 0) ? 1 : 0;
        return e;
    endfunction

    task automatic sendCommand(input logic [15:0] v);
        pid_out    = v;
        pid_valid  = 1'b1;
        exp_shadow = convert(v);
    endtask

    task automatic waitPeriodStart(output int n);
        int found;
        found = 0;
        n = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            n++;
            if (period_start)
                found = 1;
        end
        if (found == 0)
            checkOutput("period_start_timeout", found, 1);
    endtask

    // One full period of stimulus, entered on the negedge of a period_start cycle.
    task automatic applyStimulus(input int p1, input logic [15:0] v1,
                                 input int p2, input logic [15:0] v2);
        for (int ph = 0; ph < 256; ph++) begin
            pid_valid = 1'b0;
            if (ph == 0)
                checkOutput("period_start", int'(period_start), 1);
            if (ph == 128)
                checkOutput("period_start_mid", int'(period_start), 0);
            if (ph == p1)
                sendCommand(v1);
            if (ph == p2)
                sendCommand(v2);
            if (ph == 255)
                sb.push_back(exp_shadow);
            @(negedge clk);
        end
        pid_valid = 1'b0;
    endtask

    // pwm sampled in the cycles after a period_start, up to and including the
    // next one, covers exactly one period's counter values.
    always @(negedge clk) begin
        if (monitor_on != 0) begin
            pwm_count += int'(pwm);
            if (period_start) begin
                exp_t e;
                if (have_prev != 0)
                    checkOutput("pwm_high_count", pwm_count, prev_duty);
                checkOutput("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("duty_active", int'(duty_active), e.duty);
                    checkOutput("dir", int'(dir), e.dir);
                    checkOutput("sat", int'(sat), e.sat);
                    prev_duty = e.duty;
                    have_prev = 1;
                end else begin
                    have_prev = 0;
                end
                pwm_count = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        pid_out    = '0;
        pid_valid  = 1'b0;
        exp_shadow = '{0, 0, 0};
        repeat (3) @(negedge clk);
        checkOutput("rst_pwm", int'(pwm), 0);
        checkOutput("rst_dir", int'(dir), 0);
        checkOutput("rst_sat", int'(sat), 0);
        checkOutput("rst_duty", int'(duty_active), 0);
        checkOutput("rst_period_start", int'(period_start), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] enable, +0.5 / -0.25 / saturation / last-wins / bypass");
        sb.push_back(exp_shadow);
        have_prev  = 0;
        monitor_on = 1;
        enable     = 1'b1;
        waitPeriodStart(lat);
        checkOutput("enable_latency", lat, 1);
        applyStimulus(10, 16'h1000, -1, 16'h0000);
        applyStimulus(-1, 16'h0000, -1, 16'h0000);
        applyStimulus(5, 16'hF800, -1, 16'h0000);
        applyStimulus(3, 16'h4000, -1, 16'h0000);
        applyStimulus(3, 16'h8000, -1, 16'h0000);
        applyStimulus(40, 16'h0400, 100, 16'h0800);
        applyStimulus(255, 16'h0200, -1, 16'h0000);

        $display("[TB] enable dropped mid-period, command while idle, re-enable");
        repeat (77) @(negedge clk);
        monitor_on = 0;
        enable     = 1'b0;
        @(negedge clk);
        checkOutput("dis_pwm", int'(pwm), 0);
        checkOutput("dis_period_start", int'(period_start), 0);
        checkOutput("dis_duty_hold", int'(duty_active), 16);
        checkOutput("dis_dir_hold", int'(dir), 0);
        sendCommand(16'hF000);
        @(negedge clk);
        pid_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("dis_idle_strobe", int'(period_start), 0);
            checkOutput("dis_idle_pwm", int'(pwm), 0);
        end
        checkOutput("dis_duty_still", int'(duty_active), 16);
        sb.push_back(exp_shadow);
        have_prev  = 0;
        pwm_count  = 0;
        monitor_on = 1;
        enable     = 1'b1;
        waitPeriodStart(lat);
        checkOutput("reenable_latency", lat, 1);
        applyStimulus(3, 16'h4000, -1, 16'h0000);

        $display("[TB] asynchronous reset mid-period");
        repeat (200) @(negedge clk);
        monitor_on = 0;
        checkOutput("pre_rst_pwm", int'(pwm), 1);
        checkOutput("pre_rst_sat", int'(sat), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_pwm", int'(pwm), 0);
        checkOutput("arst_dir", int'(dir), 0);
        checkOutput("arst_sat", int'(sat), 0);
        checkOutput("arst_duty", int'(duty_active), 0);
        checkOutput("arst_period_start", int'(period_start), 0);
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        exp_shadow = '{0, 0, 0};
        sb.delete();
        sb.push_back(exp_shadow);
        have_prev  = 0;
        pwm_count  = 0;
        monitor_on = 1;
        waitPeriodStart(lat);
        checkOutput("post_rst_latency", lat, 1);
        applyStimulus(-1, 16'h0000, -1, 16'h0000);
        @(negedge clk);
        monitor_on = 0;
        checkOutput("sb_drained", int'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
